axi4_lite_read_master: RTL and testbench

- Bus-master side of the AXI4-Lite read path. Sits directly upstream of axi4_lite_read_slave and drives its AR channel while consuming its R channel.
- Accepts single read commands from a local requester (CPU shim or test sequencer) over a valid/ready command port. Issues one AR transfer per command and returns data and response on a valid/ready response port.
- One transaction outstanding at a time.
- Also reports per-transaction bus latency and a saturating error count for bring-up and debug.

---
 rtl/axi4_lite_pkg.sv | 17 +
 rtl/axi_sat_counter.sv | 34 +++
 rtl/axi4_lite_read_master.sv | 169 ++++++++++++++++
 tb/tb_axi4_lite_read_master.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions for the read master.
// Response codes and the master state encoding.
package axi4_lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_RESP = 2'b11
    } mst_state_e;

endpackage

// File: rtl/axi_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Sticks at all-ones instead of wrapping.
module axi_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // next count: clear wins, then increment unless saturated
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && (value_q != MAX)) begin
            value_d = value_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/axi4_lite_read_master.sv
// AXI4-Lite read master: one command in, one AR/R pair out,
// one response back, with latency and error statistics.
module axi4_lite_read_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LAT_WIDTH  = 8,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_resp,
    output logic [LAT_WIDTH-1:0]  rsp_latency,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] AR_ADDR,
    output logic                  AR_VALID,
    input  logic                  AR_READY,
    input  logic [DATA_WIDTH-1:0] R_DATA,
    input  logic                  R_VALID,
    output logic                  R_READY,
    input  logic [1:0]            R_RESP
);

    localparam logic [LAT_WIDTH-1:0] LAT_MAX = '1;

    mst_state_e state_q;
    mst_state_e state_d;

    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic                  ar_valid_q, ar_valid_d;
    logic                  r_ready_q, r_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic [LAT_WIDTH-1:0]  rsp_lat_q, rsp_lat_d;

    logic [LAT_WIDTH-1:0] lat_cnt;
    logic [LAT_WIDTH-1:0] lat_next;
    logic                 cmd_hs;
    logic                 r_hs;
    logic                 lat_clr;
    logic                 lat_inc;
    logic                 err_inc;

    assign cmd_hs = (state_q == ST_IDLE) && cmd_valid;
    assign r_hs   = (state_q == ST_DATA) && R_VALID;

    // Latency covers every cycle in ADDR and DATA; the final DATA
    // cycle is included by reporting the counter plus one.
    assign lat_clr  = reset || cmd_hs;
    assign lat_inc  = (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign lat_next = (lat_cnt == LAT_MAX) ? lat_cnt : lat_cnt + 1'b1;
    assign err_inc  = r_hs && (R_RESP != OKAY);

    axi_sat_counter #(
        .WIDTH (LAT_WIDTH)
    ) u_lat_cnt (
        .clk   (clk),
        .clr   (lat_clr),
        .inc   (lat_inc),
        .value (lat_cnt)
    );

    axi_sat_counter #(
        .WIDTH (ERR_WIDTH)
    ) u_err_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (err_inc),
        .value (err_count)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic: one transaction at a time
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_ADDR;
            ST_ADDR: if (AR_READY)  state_d = ST_DATA;
            ST_DATA: if (R_VALID)   state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
        endcase
    end

    // next values of the registered outputs, held unless an event fires
    always_comb begin
        ar_addr_d   = ar_addr_q;
        ar_valid_d  = ar_valid_q;
        r_ready_d   = r_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_lat_d   = rsp_lat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    ar_addr_d  = cmd_addr;
                    ar_valid_d = 1'b1;
                end
            end
            ST_ADDR: begin
                if (AR_READY) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            ST_DATA: begin
                if (R_VALID) begin
                    rsp_data_d  = R_DATA;
                    rsp_resp_d  = R_RESP;
                    rsp_lat_d   = lat_next;
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
        endcase
    end

    // output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_addr_q   <= '0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= OKAY;
            rsp_lat_q   <= '0;
        end else begin
            ar_addr_q   <= ar_addr_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_lat_q   <= rsp_lat_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE) && !reset;
    assign AR_ADDR     = ar_addr_q;
    assign AR_VALID    = ar_valid_q;
    assign R_READY     = r_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_latency = rsp_lat_q;

endmodule

// File: tb/tb_axi4_lite_read_master.sv
// Bench for axi4_lite_read_master: vector table of transactions
// with a response scoreboard, plus reset sequences.
module tb_axi4_lite_read_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [7:0]  rsp_latency;
    logic [7:0]  err_count;
    logic [31:0] AR_ADDR;
    logic        AR_VALID;
    logic        AR_READY;
    logic [31:0] R_DATA;
    logic        R_VALID;
    logic        R_READY;
    logic [1:0]  R_RESP;

    always #5 clk = ~clk;

    axi4_lite_read_master #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .LAT_WIDTH  (8),
        .ERR_WIDTH  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_resp    (rsp_resp),
        .rsp_latency (rsp_latency),
        .err_count   (err_count),
        .AR_ADDR     (AR_ADDR),
        .AR_VALID    (AR_VALID),
        .AR_READY    (AR_READY),
        .R_DATA      (R_DATA),
        .R_VALID     (R_VALID),
        .R_READY     (R_READY),
        .R_RESP      (R_RESP)
    );

    typedef struct {
        logic [31:0] addr;
        int          ar_dly;
        int          r_dly;
        logic [31:0] data;
        logic [1:0]  resp;
        int          stall;
        logic [7:0]  exp_lat;
        logic [7:0]  exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[7];
    vec_t post;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ar_valid"}, AR_VALID, 0);
        chk({tag, "_ar_addr"}, AR_ADDR, 0);
        chk({tag, "_r_ready"}, R_READY, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_resp"}, rsp_resp, 0);
        chk({tag, "_rsp_latency"}, rsp_latency, 0);
        chk({tag, "_err_count"}, err_count, 0);
    endtask

    task automatic do_txn(input vec_t v);
        exp_t        e;
        exp_t        g;
        logic [31:0] d0;
        logic [1:0]  r0;
        logic [7:0]  l0;
        // spurious slave activity while idle must be ignored
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        AR_READY  = 1'b1;
        R_VALID   = 1'b1;
        R_DATA    = 32'hFFFF_0000;
        R_RESP    = 2'b11;
        tick;
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_ar_valid", AR_VALID, 0);
        chk("idle_r_ready", R_READY, 0);
        chk("idle_cmd_ready", cmd_ready, 1);
        AR_READY  = 1'b0;
        R_VALID   = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        chk("cmd_ready", cmd_ready, 1);
        e.data = v.data;
        e.resp = v.resp;
        e.lat  = v.exp_lat;
        sb.push_back(e);
        tick;
        // keep cmd_valid up with a different address: must be ignored
        cmd_addr = ~v.addr;
        chk("ar_valid", AR_VALID, 1);
        chk("ar_addr", AR_ADDR, {32'h0, v.addr});
        chk("busy_cmd_ready", cmd_ready, 0);
        for (int i = 0; i < v.ar_dly; i++) begin
            R_VALID = (i % 2 == 0);
            tick;
            chk("stall_ar_valid", AR_VALID, 1);
            chk("stall_ar_addr", AR_ADDR, {32'h0, v.addr});
            chk("stall_r_ready", R_READY, 0);
        end
        // AR and R together in ADDR: only the AR handshake counts
        AR_READY = 1'b1;
        R_VALID  = 1'b1;
        R_DATA   = 32'h0;
        R_RESP   = 2'b11;
        tick;
        AR_READY = 1'b0;
        R_VALID  = 1'b0;
        chk("data_ar_valid", AR_VALID, 0);
        chk("data_r_ready", R_READY, 1);
        chk("data_rsp_valid", rsp_valid, 0);
        for (int i = 0; i < v.r_dly; i++) begin
            tick;
            chk("rwait_r_ready", R_READY, 1);
            chk("rwait_rsp_valid", rsp_valid, 0);
        end
        R_VALID = 1'b1;
        R_DATA  = v.data;
        R_RESP  = v.resp;
        tick;
        R_VALID   = 1'b0;
        R_DATA    = ~v.data;
        cmd_valid = 1'b0;
        chk("rsp_valid", rsp_valid, 1);
        chk("resp_r_ready", R_READY, 0);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
        end else begin
            g = sb.pop_front();
            chk("rsp_data", rsp_data, {32'h0, g.data});
            chk("rsp_resp", rsp_resp, g.resp);
            chk("rsp_latency", rsp_latency, g.lat);
        end
        chk("err_count", err_count, v.exp_err);
        d0 = rsp_data;
        r0 = rsp_resp;
        l0 = rsp_latency;
        for (int i = 0; i < v.stall; i++) begin
            tick;
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, {32'h0, d0});
            chk("bp_rsp_resp", rsp_resp, r0);
            chk("bp_rsp_latency", rsp_latency, l0);
            chk("bp_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        chk("hs_cmd_ready", cmd_ready, 0);
        tick;
        rsp_ready = 1'b0;
        chk("done_rsp_valid", rsp_valid, 0);
        chk("done_cmd_ready", cmd_ready, 1);
        chk("done_rsp_data", rsp_data, {32'h0, d0});
    endtask

    initial begin
        tbl[0] = '{32'h0000_0010, 0, 0, 32'hDEAD_BEEF, 2'b00, 0, 8'd2, 8'd0};
        tbl[1] = '{32'h0000_0010, 0, 0, 32'h1234_5678, 2'b00, 0, 8'd2, 8'd0};
        tbl[2] = '{32'h2000_0004, 3, 4, 32'hCAFE_F00D, 2'b00, 0, 8'd9, 8'd0};
        tbl[3] = '{32'h3000_0008, 1, 1, 32'hBAAD_F00D, 2'b10, 5, 8'd4, 8'd1};
        tbl[4] = '{32'h0000_0004, 0, 2, 32'h0BAD_0BAD, 2'b11, 1, 8'd4, 8'd2};
        tbl[5] = '{32'hFFFF_FFFC, 300, 0, 32'h55AA_55AA, 2'b01, 0, 8'd255, 8'd3};
        tbl[6] = '{32'h0000_0008, 2, 0, 32'h0000_0001, 2'b00, 2, 8'd4, 8'd3};
        post   = '{32'h0000_000C, 0, 1, 32'h0000_0077, 2'b00, 0, 8'd3, 8'd0};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 32'h0;
        rsp_ready = 1'b0;
        AR_READY  = 1'b0;
        R_VALID   = 1'b0;
        R_DATA    = 32'h0;
        R_RESP    = 2'b00;

        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst_cmd_ready", cmd_ready, 0);
            check_reset_outputs("rst");
        end
        reset = 1'b0;
        tick;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 7; i++) begin
            do_txn(tbl[i]);
        end

        // reset while waiting in DATA abandons the transaction
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_0100;
        tick;
        cmd_valid = 1'b0;
        AR_READY  = 1'b1;
        tick;
        AR_READY  = 1'b0;
        chk("mid_r_ready_before", R_READY, 1);
        chk("mid_err_before", err_count, 3);
        reset   = 1'b1;
        R_VALID = 1'b1;
        R_DATA  = 32'hABCD_0123;
        R_RESP  = 2'b10;
        tick;
        chk("mid_cmd_ready", cmd_ready, 0);
        check_reset_outputs("mid");
        reset   = 1'b0;
        R_VALID = 1'b0;
        tick;
        chk("mid_idle_cmd_ready", cmd_ready, 1);
        check_reset_outputs("mid_idle");
        do_txn(post);

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
